// File: rtl/render_scheduler_pkg.sv
// Scheduler-local types: FSM states, default screen size and the signed
// coordinate type used for visibility arithmetic.
package render_scheduler_pkg;

    localparam int DEF_SCREEN_W = 1280;
    localparam int DEF_SCREEN_H = 300;
    localparam int COORD_W      = 14;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        ISSUE,
        DONE
    } sched_state_t;

endpackage

// File: rtl/runner_pkg.sv
// Shared game-side types: render slot count and the sprite/position records
// that game logic writes and the renderer consumes.
package runner_pkg;

    localparam int RENDER_SLOTS = 32;
    localparam int SPRITE_DIM_W = 12;
    localparam int POS_W        = 12;

    typedef struct packed {
        logic [SPRITE_DIM_W-1:0] x;
        logic [SPRITE_DIM_W-1:0] y;
        logic [SPRITE_DIM_W-1:0] w;
        logic [SPRITE_DIM_W-1:0] h;
    } sprite_t;

    // Two's-complement screen position; may sit partly or fully off screen.
    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } pos_t;

endpackage

// File: rtl/render_scheduler_sprite_clip.sv
// Combinational visibility test for one sprite rectangle against the screen.
// Kept free of scheduler state so the painter can reuse it.
module sprite_clip
    import runner_pkg::*;
    import render_scheduler_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic [SPRITE_DIM_W-1:0] i_w,
    input  logic [SPRITE_DIM_W-1:0] i_h,
    input  pos_t                    i_pos,
    output logic                    o_visible
);

    localparam coord_t SCR_W = coord_t'(SCREEN_W);
    localparam coord_t SCR_H = coord_t'(SCREEN_H);
    localparam coord_t ZERO  = '0;

    coord_t w_x;
    coord_t w_y;
    coord_t w_w;
    coord_t w_h;
    coord_t w_right;
    coord_t w_bottom;

    // Position is sign-extended, extents zero-extended, so edges compare signed.
    assign w_x      = {{(COORD_W-POS_W){i_pos.x[POS_W-1]}}, i_pos.x};
    assign w_y      = {{(COORD_W-POS_W){i_pos.y[POS_W-1]}}, i_pos.y};
    assign w_w      = {{(COORD_W-SPRITE_DIM_W){1'b0}}, i_w};
    assign w_h      = {{(COORD_W-SPRITE_DIM_W){1'b0}}, i_h};
    assign w_right  = w_x + w_w;
    assign w_bottom = w_y + w_h;

    assign o_visible = (i_w != '0) && (i_h != '0)
                    && (w_x < SCR_W) && (w_right > ZERO)
                    && (w_y < SCR_H) && (w_bottom > ZERO);

endmodule

// File: rtl/render_scheduler.sv
// Frame controller: snapshots all render slots on frame start, requests a
// clear, then issues one blit per visible slot in ascending slot order.
module render_scheduler
    import runner_pkg::*;
    import render_scheduler_pkg::*;
#(
    parameter int SLOTS    = RENDER_SLOTS,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_frame_start,
    input  sprite_t                  i_sprite [SLOTS],
    input  pos_t                     i_pos    [SLOTS],
    output logic                     o_clear_valid,
    input  logic                     i_clear_ready,
    output logic                     o_blit_valid,
    input  logic                     i_blit_ready,
    output sprite_t                  o_blit_sprite,
    output pos_t                     o_blit_pos,
    output logic [$clog2(SLOTS)-1:0] o_blit_slot,
    output logic                     o_frame_done,
    output logic                     o_busy,
    output logic                     o_overrun,
    output logic [$clog2(SLOTS):0]   o_drawn_count
);

    localparam int               IDX_W = $clog2(SLOTS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(SLOTS - 1);

    sched_state_t     r_state;
    logic [IDX_W-1:0] r_slotIdx;
    logic [IDX_W:0]   r_count;
    sprite_t          r_snapSprite [SLOTS];
    pos_t             r_snapPos    [SLOTS];

    sprite_t w_curSprite;
    pos_t    w_curPos;
    logic    w_visible;

    // The snapshot is the only place live slot inputs are read, so game-side
    // updates during painting cannot tear the frame.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && i_frame_start) begin
            r_snapSprite <= i_sprite;
            r_snapPos    <= i_pos;
        end
    end

    assign w_curSprite = r_snapSprite[r_slotIdx];
    assign w_curPos    = r_snapPos[r_slotIdx];

    sprite_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip (
        .i_w       (w_curSprite.w),
        .i_h       (w_curSprite.h),
        .i_pos     (w_curPos),
        .o_visible (w_visible)
    );

    // Outputs are loaded on the transition into each state so they are
    // registered and line up with the state they decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_slotIdx     <= '0;
            r_count       <= '0;
            o_clear_valid <= 1'b0;
            o_blit_valid  <= 1'b0;
            o_blit_sprite <= '0;
            o_blit_pos    <= '0;
            o_blit_slot   <= '0;
            o_frame_done  <= 1'b0;
            o_busy        <= 1'b0;
            o_overrun     <= 1'b0;
            o_drawn_count <= '0;
        end else begin
            o_overrun <= i_frame_start && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (i_frame_start) begin
                        r_slotIdx     <= '0;
                        r_count       <= '0;
                        o_clear_valid <= 1'b1;
                        o_busy        <= 1'b1;
                        r_state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (i_clear_ready) begin
                        o_clear_valid <= 1'b0;
                        r_state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_visible) begin
                        o_blit_valid  <= 1'b1;
                        o_blit_sprite <= w_curSprite;
                        o_blit_pos    <= w_curPos;
                        o_blit_slot   <= r_slotIdx;
                        r_state       <= ISSUE;
                    end else if (r_slotIdx == LAST) begin
                        o_frame_done <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_slotIdx <= r_slotIdx + 1'b1;
                    end
                end
                ISSUE: begin
                    if (i_blit_ready) begin
                        o_blit_valid <= 1'b0;
                        r_count      <= r_count + 1'b1;
                        if (r_slotIdx == LAST) begin
                            o_frame_done <= 1'b1;
                            r_state      <= DONE;
                        end else begin
                            r_slotIdx <= r_slotIdx + 1'b1;
                            r_state   <= SCAN;
                        end
                    end
                end
                DONE: begin
                    o_frame_done  <= 1'b0;
                    o_busy        <= 1'b0;
                    o_drawn_count <= r_count;
                    r_state       <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_render_scheduler.sv
// Scoreboard bench for render_scheduler: frames are described by slot contents,
// expected blits come from the visibility rules evaluated on plain integers.
module tb_render_scheduler;
    import runner_pkg::*;

    localparam int SLOTS  = RENDER_SLOTS;
    localparam int SW     = 1280;
    localparam int SH     = 300;
    localparam int IDX_W  = $clog2(SLOTS);
    localparam int LIMIT  = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frameStart = 1'b0;
    logic clearReady = 1'b1;
    logic blitReady  = 1'b1;
    sprite_t slotSprite [SLOTS];
    pos_t    slotPos    [SLOTS];

    logic             oClearValid;
    logic             oBlitValid;
    sprite_t          oBlitSprite;
    pos_t             oBlitPos;
    logic [IDX_W-1:0] oBlitSlot;
    logic             oFrameDone;
    logic             oBusy;
    logic             oOverrun;
    logic [IDX_W:0]   oDrawnCount;

    render_scheduler #(
        .SLOTS    (SLOTS),
        .SCREEN_W (SW),
        .SCREEN_H (SH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_frame_start (frameStart),
        .i_sprite      (slotSprite),
        .i_pos         (slotPos),
        .o_clear_valid (oClearValid),
        .i_clear_ready (clearReady),
        .o_blit_valid  (oBlitValid),
        .i_blit_ready  (blitReady),
        .o_blit_sprite (oBlitSprite),
        .o_blit_pos    (oBlitPos),
        .o_blit_slot   (oBlitSlot),
        .o_frame_done  (oFrameDone),
        .o_busy        (oBusy),
        .o_overrun     (oOverrun),
        .o_drawn_count (oDrawnCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int      slot;
        sprite_t spr;
        pos_t    pos;
    } blit_t;

    blit_t expBlits [$];
    int    expCounts [$];
    int    checks = 0;
    int    failures = 0;
    int    doneSeen = 0;
    int    blitSeen = 0;
    int    ovSeen = 0;
    bit    randomReady = 1'b0;
    bit    prevStall = 1'b0;
    bit    countPending = 1'b0;
    int    countExp = 0;
    blit_t heldBlit;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Visibility straight from the rules, using ordinary signed integers.
    function automatic bit refVisible(input sprite_t s, input pos_t p);
        int x;
        int y;
        int w;
        int h;
        x = $signed(p.x);
        y = $signed(p.y);
        w = int'(s.w);
        h = int'(s.h);
        return (w > 0) && (h > 0) && (x < SW) && (x + w > 0) && (y < SH) && (y + h > 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearSlots();
        for (int k = 0; k < SLOTS; k++) begin
            slotSprite[k] = '0;
            slotPos[k]    = '0;
        end
    endtask

    task automatic setSlot(input int k, input int sx, input int sy, input int w, input int h,
                           input int px, input int py);
        slotSprite[k].x = 12'(sx);
        slotSprite[k].y = 12'(sy);
        slotSprite[k].w = 12'(w);
        slotSprite[k].h = 12'(h);
        slotPos[k].x    = 12'(px);
        slotPos[k].y    = 12'(py);
    endtask

    // Pushes the frame's expected blits and count, then pulses frame_start.
    task automatic applyStimulus();
        blit_t b;
        int    n;
        n = 0;
        for (int k = 0; k < SLOTS; k++) begin
            if (refVisible(slotSprite[k], slotPos[k])) begin
                b.slot = k;
                b.spr  = slotSprite[k];
                b.pos  = slotPos[k];
                expBlits.push_back(b);
                n++;
            end
        end
        expCounts.push_back(n);
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
    endtask

    task automatic waitDone(output int cyc);
        cyc = 1;
        while (!oFrameDone && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        checkOutput("frame_done_reached", 64'(oFrameDone), 64'd1);
    endtask

    // Random backpressure on both request channels when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (randomReady) begin
                blitReady  = ($urandom_range(0, 3) != 0);
                clearReady = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted blit and on frame_done,
    // and checks that a stalled request holds its data.
    always @(negedge clk) begin
        blit_t e;
        if (rst) begin
            prevStall    = 1'b0;
            countPending = 1'b0;
        end else begin
            if (countPending) begin
                checkOutput("drawn_count", 64'(oDrawnCount), 64'(countExp));
                countPending = 1'b0;
            end
            if (oBlitValid) begin
                if (prevStall) begin
                    checkOutput("stall_hold_slot", 64'(oBlitSlot), 64'(heldBlit.slot));
                    checkOutput("stall_hold_sprite", 64'(oBlitSprite), 64'(heldBlit.spr));
                    checkOutput("stall_hold_pos", 64'(oBlitPos), 64'(heldBlit.pos));
                end
                if (blitReady) begin
                    blitSeen++;
                    checks++;
                    if (expBlits.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL unexpected_blit: slot %0d issued with nothing expected", oBlitSlot);
                    end else begin
                        e = expBlits.pop_front();
                        checkOutput("blit_slot", 64'(oBlitSlot), 64'(e.slot));
                        checkOutput("blit_sprite", 64'(oBlitSprite), 64'(e.spr));
                        checkOutput("blit_pos", 64'(oBlitPos), 64'(e.pos));
                    end
                    prevStall = 1'b0;
                end else begin
                    prevStall     = 1'b1;
                    heldBlit.slot = int'(oBlitSlot);
                    heldBlit.spr  = oBlitSprite;
                    heldBlit.pos  = oBlitPos;
                end
            end else if (prevStall) begin
                checkOutput("valid_dropped_without_transfer", 64'(oBlitValid), 64'd1);
                prevStall = 1'b0;
            end
            if (oOverrun) ovSeen++;
            if (oFrameDone) begin
                doneSeen++;
                checks++;
                if (expCounts.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_frame_done: got pulse expected none");
                end else begin
                    countExp     = expCounts.pop_front();
                    countPending = 1'b1;
                end
                checkOutput("blits_pending_at_done", 64'(expBlits.size()), 64'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int b0;
        int d0;
        int ov0;
        int tmp;

        clearSlots();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        $display("[TB] reset values");
        checkOutput("rst_clear_valid", 64'(oClearValid), 64'd0);
        checkOutput("rst_blit_valid", 64'(oBlitValid), 64'd0);
        checkOutput("rst_frame_done", 64'(oFrameDone), 64'd0);
        checkOutput("rst_busy", 64'(oBusy), 64'd0);
        checkOutput("rst_overrun", 64'(oOverrun), 64'd0);
        checkOutput("rst_blit_fields", {oBlitSprite, 16'(oBlitSlot)}, 64'd0);
        checkOutput("rst_blit_pos", 64'(oBlitPos), 64'd0);
        checkOutput("rst_drawn_count", 64'(oDrawnCount), 64'd0);

        $display("[TB] all-empty frame");
        b0 = blitSeen;
        applyStimulus();
        checkOutput("clear_valid_cycle1", 64'(oClearValid), 64'd1);
        checkOutput("busy_in_frame", 64'(oBusy), 64'd1);
        waitDone(cyc);
        checkOutput("empty_done_cycle", 64'(cyc), 64'(2 + SLOTS));
        checkOutput("empty_no_blits", 64'(blitSeen - b0), 64'd0);
        tick();
        checkOutput("busy_after_done", 64'(oBusy), 64'd0);

        $display("[TB] visible slots 0 and 18");
        setSlot(0, 2, 104, 1200, 24, 0, 254);
        setSlot(18, 1678, 2, 88, 94, 100, 186);
        b0 = blitSeen;
        applyStimulus();
        waitDone(cyc);
        tick();
        checkOutput("two_blits", 64'(blitSeen - b0), 64'd2);

        $display("[TB] clipping edges");
        clearSlots();
        setSlot(11, 0, 0, 50, 10, -50, 10);
        setSlot(12, 0, 0, 10, 10, 1280, 10);
        setSlot(13, 0, 0, 50, 10, -49, 10);
        b0 = blitSeen;
        applyStimulus();
        waitDone(cyc);
        tick();
        checkOutput("clip_blits", 64'(blitSeen - b0), 64'd1);

        $display("[TB] backpressure");
        clearSlots();
        setSlot(3, 5, 6, 20, 20, 100, 100);
        setSlot(4, 7, 8, 30, 30, 200, 50);
        blitReady = 1'b0;
        applyStimulus();
        cyc = 0;
        while (!oBlitValid && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        checkOutput("bp_valid_seen", 64'(oBlitValid), 64'd1);
        repeat (5) tick();
        checkOutput("bp_slot_held", 64'(oBlitSlot), 64'd3);
        blitReady = 1'b1;
        waitDone(cyc);
        tick();

        $display("[TB] snapshot and overrun");
        clearSlots();
        setSlot(0, 2, 104, 1200, 24, 0, 254);
        setSlot(18, 1678, 2, 88, 94, 100, 186);
        ov0 = ovSeen;
        applyStimulus();
        repeat (5) tick();
        slotPos[18].x = 12'(640);
        slotPos[18].y = 12'(20);
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        waitDone(cyc);
        tick();
        checkOutput("overrun_pulses", 64'(ovSeen - ov0), 64'd1);

        $display("[TB] reset mid-frame");
        clearSlots();
        setSlot(5, 1, 1, 40, 40, 300, 100);
        blitReady = 1'b0;
        applyStimulus();
        cyc = 0;
        while (!oBlitValid && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        checkOutput("rst_test_in_issue", 64'(oBlitValid), 64'd1);
        rst = 1'b1;
        tick();
        checkOutput("midrst_blit_valid", 64'(oBlitValid), 64'd0);
        checkOutput("midrst_busy", 64'(oBusy), 64'd0);
        expBlits.delete();
        expCounts.delete();
        rst = 1'b0;
        blitReady = 1'b1;
        d0 = doneSeen;
        repeat (40) tick();
        checkOutput("midrst_no_done", 64'(doneSeen - d0), 64'd0);
        applyStimulus();
        waitDone(cyc);
        tick();

        $display("[TB] randomized frames");
        randomReady = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < SLOTS; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    slotSprite[k] = '0;
                    slotPos[k]    = '0;
                end else begin
                    slotSprite[k].x = 12'($urandom_range(0, 4095));
                    slotSprite[k].y = 12'($urandom_range(0, 4095));
                    slotSprite[k].w = 12'($urandom_range(0, 160));
                    slotSprite[k].h = 12'($urandom_range(0, 120));
                    tmp = int'($urandom_range(0, 1500)) - 150;
                    slotPos[k].x = 12'(tmp);
                    tmp = int'($urandom_range(0, 500)) - 120;
                    slotPos[k].y = 12'(tmp);
                end
            end
            applyStimulus();
            waitDone(cyc);
            tick();
        end
        randomReady = 1'b0;
        tick();
        blitReady  = 1'b1;
        clearReady = 1'b1;
        repeat (3) tick();

        checkOutput("scoreboard_blits_empty", 64'(expBlits.size()), 64'd0);
        checkOutput("scoreboard_counts_empty", 64'(expCounts.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/render_scheduler.md
# render_scheduler

Frame-level controller between the game-logic sprite slot array and the framebuffer painter. On each frame start it snapshots all render slots, requests a framebuffer clear, then walks the slots in ascending order and issues one blit request per visible sprite over a valid/ready handshake. When the walk finishes, it pulses `frame_done`, which drives the game loop's `painter_finished` input.

## Interface
Parameters:
- `SLOTS`, default `runner_pkg::RENDER_SLOTS` (32): number of render slots walked per frame.
- `SCREEN_W`, default 1280: visible width in pixels (game width ×2).
- `SCREEN_H`, default 300: visible height in pixels (game height ×2).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `frame_start` in 1: one-cycle pulse (buffer swap / vblank) that starts a frame.
- `sprite` in `sprite_t[SLOTS]`: per-slot sprite sheet rectangle `{x,y,w,h}`.
- `pos` in `pos_t[SLOTS]`: per-slot signed screen position.
- `clear_valid` out 1: framebuffer clear request.
- `clear_ready` in 1: painter accepts the clear.
- `blit_valid` out 1: blit request valid.
- `blit_ready` in 1: painter accepts the blit.
- `blit_sprite` out `sprite_t`: rectangle of the current blit.
- `blit_pos` out `pos_t`: position of the current blit.
- `blit_slot` out `$clog2(SLOTS)`: slot index of the current blit.
- `frame_done` out 1: one-cycle pulse when the frame is fully issued.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: one-cycle pulse when `frame_start` arrives while busy.
- `drawn_count` out `$clog2(SLOTS)+1`: blits issued in the last completed frame.

## Operation
States are IDLE, CLEAR, SCAN, ISSUE, DONE.

- **IDLE**
  - On `frame_start`, latch `sprite`/`pos` for all slots into a snapshot.
  - Zero the slot index and the running blit count.
  - Go to CLEAR.
  - Live inputs are never read after the snapshot, so game updates during painting cannot tear the frame.
- **CLEAR**
  - `clear_valid`=1.
  - On `clear_valid && clear_ready`, go to SCAN.
- **SCAN** (one cycle per slot): evaluate visibility of snapshot slot `i`.
  - A slot is **invisible** if any of these holds:
    - `w==0` or `h==0`;
    - `x >= SCREEN_W`;
    - `x + w <= 0`;
    - `y >= SCREEN_H`;
    - `y + h <= 0`.
  - Arithmetic is signed at 14 bits: `pos` is sign-extended and `w`/`h` are zero-extended.
  - Visible → go to ISSUE.
  - Invisible with `i==SLOTS-1` → go to DONE.
  - Invisible otherwise → `i+1`, stay in SCAN.
- **ISSUE**
  - `blit_valid`=1, with `blit_sprite`/`blit_pos`/`blit_slot` from snapshot slot `i`.
  - Outputs stay stable until the handshake completes.
  - On `blit_valid && blit_ready`: increment the running count; if `i==SLOTS-1` go to DONE, else `i+1` and go to SCAN.
  - Unclipped coordinates are passed through; the painter clips pixels.
- **DONE**
  - `frame_done`=1 for exactly one cycle.
  - `drawn_count` ← running count.
  - Go to IDLE.
- **Draw order:** ascending slot index, so higher slots overdraw lower ones (horizon at slot 0 is drawn first).
- **`frame_start` while busy:** ignored for sequencing, and `overrun` pulses on the same cycle.
- **`frame_start` in DONE:** counts as busy; it is ignored and `overrun` pulses.

## Timing
- **Reset values:**
  - state IDLE;
  - `clear_valid`, `blit_valid`, `frame_done`, `overrun`, `busy` = 0;
  - `blit_sprite`/`blit_pos`/`blit_slot`/`drawn_count` = 0.
- **Reset mid-frame:** all outputs return to reset values at the next edge. No partial `frame_done` is ever emitted.
- **Output registering:** all outputs are registered, state-decoded from the current state.
- **CLEAR timing:** `frame_start` sampled at edge N → `clear_valid`=1 from cycle N+1.
- **SCAN timing:** `clear_ready` high at cycle M → SCAN for slot 0 at M+1.
- **Per-slot cost:**
  - invisible slot: 1 cycle;
  - visible slot: 1 SCAN cycle plus at least 1 ISSUE cycle.
- **Handshake rules:**
  - valid never drops without a transfer, except on `rst`;
  - `ready` may be held constantly high.
- **All-empty frame:** with ready held high, `frame_start` at cycle 0 gives `frame_done` at cycle `2+SLOTS` (34 for 32 slots).

## Structure
- **`render_scheduler_pkg`:**
  - `sched_state_t` enum;
  - default `SCREEN_W`/`SCREEN_H`;
  - a 14-bit signed coordinate typedef.
- **Reuses from `runner_pkg`:** `sprite_t`, `pos_t`, `RENDER_SLOTS`.
- **Sub-module `sprite_clip`:** combinational visibility test (`sprite_t`, `pos_t`, screen size → `visible`), instantiated once on the snapshot mux output. It is reusable by the painter.

## Test plan
- **All slots zero:**
  - stimulus: `frame_start`, ready tied high;
  - response: `clear_valid` at cycle 1, `frame_done` at cycle 34, `drawn_count`=0, no `blit_valid`.
- **Visible slots 0 and 18:**
  - stimulus: slot 0 `{2,104,1200,24}` at `(0,254)`; slot 18 `{1678,2,88,94}` at `(100,186)`;
  - response: exactly 2 blits, slot 0 then slot 18, with matching fields; `drawn_count`=2.
- **Clipping:**
  - stimulus: slot 11 at `x=-50, w=50`; slot 12 at `x=1280`; slot 13 at `x=-49, w=50`;
  - response: only slot 13 blitted.
- **Backpressure:**
  - stimulus: `blit_ready` low for 5 cycles on the first blit;
  - response: `blit_valid` held with stable data; the next slot is not scanned until the transfer.
- **Snapshot and overrun:**
  - stimulus: change slot 18 `pos` and pulse `frame_start` mid-frame;
  - response: the old `pos` is blitted, `overrun` pulses once, and the frame completes normally.
- **Reset mid-frame:**
  - stimulus: `rst` during ISSUE;
  - response: `blit_valid`=0 next cycle, `busy`=0, no `frame_done`; the next `frame_start` runs a full frame.
